// File: rtl/result_collector.sv
// result_collector: assembles an N x N result matrix from the edge outputs
// of a systolic array. Each column has its own row counter, so columns may
// drain with any skew. The finished matrix is offered to a consumer through
// o_valid/i_ready.
// Optional feature: define RESULT_COLLECTOR_ERR_EN to build the sticky
// dropped-beat error flag. When it is undefined, o_err is tied to 0.
//
// Handshake: o_valid is high for the whole of DONE, and o_C is stable while
// o_valid is high. The matrix is taken in the cycle where o_valid and i_ready
// are both high. The block then returns to IDLE on the next edge, and o_C
// keeps its last value. i_ready has no effect outside DONE.
module result_collector #(
    parameter int W = 16,
    parameter int N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [W*N-1:0]   i_edge,
    input  logic [N-1:0]     i_edge_vld,
    input  logic             i_ready,
    output logic [W*N*N-1:0] o_C,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_err,
    output logic [1:0]       o_state
);

    localparam int CW = $clog2(N + 1);
    localparam logic [1:0]    ST_IDLE    = 2'd0;
    localparam logic [1:0]    ST_COLLECT = 2'd1;
    localparam logic [1:0]    ST_DONE    = 2'd2;
    localparam logic [CW-1:0] K_FULL     = CW'(N);

    logic [1:0]       state_q;
    logic [CW-1:0]    k_q [N];
    logic [W*N*N-1:0] c_q;
    logic [N-1:0]     acc;
    logic             all_full;

    // Accept a beat per column while collecting and the column is not full.
    // Also look ahead: are all columns full once this cycle's beats land?
    always_comb begin
        acc      = '0;
        all_full = 1'b1;
        for (int j = 0; j < N; j++) begin
            acc[j] = (state_q == ST_COLLECT) && i_edge_vld[j] && (k_q[j] != K_FULL);
            if ((k_q[j] + CW'(acc[j])) != K_FULL) begin
                all_full = 1'b0;
            end
        end
    end

    // State machine, column counters and matrix storage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            for (int j = 0; j < N; j++) begin
                k_q[j] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_en) begin
                        state_q <= ST_COLLECT;
                        c_q     <= '0;
                        for (int j = 0; j < N; j++) begin
                            k_q[j] <= '0;
                        end
                    end
                end
                ST_COLLECT: begin
                    for (int j = 0; j < N; j++) begin
                        if (acc[j]) begin
                            c_q[(N*N - 1 - (int'(k_q[j]) * N + j)) * W +: W] <= i_edge[(N - 1 - j) * W +: W];
                            k_q[j] <= k_q[j] + CW'(1);
                        end
                    end
                    if (all_full) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef RESULT_COLLECTOR_ERR_EN
    logic err_q;
    logic drop;

    // A beat is dropped if it arrives when it cannot be accepted.
    assign drop = |(i_edge_vld & ~acc);

    // The error flag is sticky. Only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (drop) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_C     = c_q;
    assign o_valid = (state_q == ST_DONE);
    assign o_busy  = (state_q == ST_COLLECT);
    assign o_state = state_q;

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning element width in bits (fp16 result word, passed through unmodified).
REQ-002 The block SHALL have parameter N, default 3, meaning array dimension; the result matrix is N x N.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_en, input, 1 bit: arm pulse that starts a collection run.
REQ-006 The block SHALL have port i_edge, input, W*N bits: array edge outputs; column j at bits [(N-1-j)*W +: W].
REQ-007 The block SHALL have port i_edge_vld, input, N bits: bit j qualifies column j of i_edge for one beat.
REQ-008 The block SHALL have port i_ready, input, 1 bit: consumer accepts the assembled matrix.
REQ-009 The block SHALL have port o_C, output, W*N*N bits: assembled matrix; C[r][c] at bits [(N*N-1-(r*N+c))*W +: W], so C[0][0] is in the MSBs.
REQ-010 The block SHALL have port o_valid, output, 1 bit: o_C complete and stable.
REQ-011 The block SHALL have port o_busy, output, 1 bit: run in progress (state COLLECT).
REQ-012 The block SHALL have port o_err, output, 1 bit: sticky protocol error flag.

Function
REQ-013 The block SHALL implement states IDLE, COLLECT and DONE; o_busy=1 only in COLLECT, and o_valid=1 only in DONE.
REQ-014 In IDLE, i_en=1 SHALL cause a transition to COLLECT next cycle, clearing all column counters and o_C to 0.
REQ-015 i_en SHALL be ignored in COLLECT and DONE.
REQ-016 Each column j SHALL keep a counter k_j in 0..N; the counter width is clog2(N+1).
REQ-017 In COLLECT, a beat (i_edge_vld[j]=1 with k_j<N) SHALL write column j of i_edge into C[k_j][j] and increment k_j.
REQ-018 Columns SHALL be independent: arbitrary skew between columns and any simultaneous combination of valid bits SHALL be accepted in the same cycle.
REQ-019 A beat to a column with k_j=N SHALL be dropped, leaving o_C unchanged.
REQ-020 Beats in IDLE or DONE SHALL be dropped.
REQ-021 When all k_j=N after a cycle's updates, the state SHALL become DONE on the next edge; o_valid rises exactly 1 cycle after the last accepted beat, and o_C includes that beat.
REQ-022 In DONE, o_C SHALL hold stable; i_ready=1 SHALL cause a return to IDLE next cycle, where o_valid=0 and o_C holds its last value.
REQ-023 i_ready SHALL be ignored outside DONE.
REQ-024 Element values SHALL be stored bit-exact, with no arithmetic performed.

Reset
REQ-025 When i_rst=1 at a clock edge, the next state SHALL be IDLE, with o_C=0, o_valid=0, o_busy=0, o_err=0 and all k_j=0.
REQ-026 Reset SHALL take priority over i_en, beats and i_ready in the same cycle.
REQ-027 Reset SHALL apply identically mid-COLLECT and in DONE, and any partial result SHALL be discarded.

Configuration
REQ-028 Macro RESULT_COLLECTOR_ERR_EN SHALL control error detection.
REQ-029 With RESULT_COLLECTOR_ERR_EN defined, o_err SHALL be set the cycle after any dropped beat (REQ-019, REQ-020), and SHALL be cleared only by i_rst.
REQ-030 Without RESULT_COLLECTOR_ERR_EN, o_err SHALL be constant 0, no error logic SHALL be synthesised, and drop behaviour SHALL be unchanged.

Verification
REQ-031 Skewed drain: pulse i_en, then drive column j beats at cycles j+1..j+3 with C[r][c]=16'h0100*(r*3+c+1). o_valid=1 at cycle 6, and o_C={0100,0200,...,0900} in C[0][0]-first order.
REQ-032 Unskewed drain: i_edge_vld=3'b111 for 3 consecutive cycles. o_valid=1 exactly 1 cycle after the third beat, and o_busy=0 from then on.
REQ-033 Backpressure: i_ready=0 for 5 cycles in DONE. o_valid stays 1 and o_C stays bit-stable; then i_ready=1 gives o_valid=0 next cycle, and a second run with all elements 16'h3c00 assembles correctly.
REQ-034 Reset mid-run: assert i_rst after 2 beats per column. Next cycle o_busy=0, o_C=0 and o_err=0; a fresh run produces the REQ-031 result.
REQ-035 Extra beat: drive a 4th beat on column 0 in COLLECT, plus one beat while in IDLE. With RESULT_COLLECTOR_ERR_EN, o_err=1 and remains set until i_rst; without it, o_err=0. In both builds, o_C is unaffected.
